mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 16-bit 5-stage pipeline; consumes the EX/MEM register outputs of the EX stage.
//  Runs the data-memory access over a req/ack handshake and drives stall_out while the access is pending.
//  Owns the MEM/WB register, whose data also feeds back to EX as the MEM->EX forward operand (memex_data).
//  Forwards MEM/WB data onto store data (MEM->MEM) for load-then-store sequences.
// PARAMETERS
//  DATA_W    16   datapath / memory word width
//  ADDR_W    16   memory address width (word addressed, mem_addr = result[ADDR_W-1:0])
//  MAX_WAIT  15   max cycles in BUSY before the access is abandoned (timeout)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  rf_write       in   1       EX/MEM: writes register file
//  dm_write       in   1       EX/MEM: store
//  memtoreg       in   1       EX/MEM: load
//  rf_data_out2   in   DATA_W  EX/MEM: store data from register file
//  result         in   DATA_W  EX/MEM: ALU result / address
//  rf_read_reg2   in   4       EX/MEM: store-data source register
//  rf_write_reg   in   4       EX/MEM: destination register
//  branch         in   3       EX/MEM: branch code, passed through
//  mem_req        out  1       memory request, held until ack
//  mem_wr         out  1       1 = write, 0 = read
//  mem_addr       out  ADDR_W  request address
//  mem_wdata      out  DATA_W  write data
//  mem_rdata      in   DATA_W  read data, valid with mem_ack
//  mem_ack        in   1       access complete
//  stall_out      out  1       freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  mem_err        out  1       sticky timeout flag
//  rf_write_wb    out  1       MEM/WB: register write enable
//  rf_write_reg_wb out 4       MEM/WB: destination register
//  wb_data        out  DATA_W  MEM/WB: write-back data (also memex_data to EX)
//  branch_wb      out  3       MEM/WB: branch code
// BEHAVIOUR
//  - Reset: state IDLE, wait_cnt 0, mem_req 0, stall_out 0, mem_err 0, all MEM/WB outputs 0.
//  - memop = memtoreg | dm_write. Bubble = all control inputs 0; a bubble never requests.
//  - FSM IDLE: memop -> mem_req=1, stall_out=1, next BUSY; else stall_out=0, no request.
//  - FSM BUSY: mem_req=1; addr/wr/wdata held stable.
//      ack=1 -> stall_out=0, MEM/WB loads, next IDLE.
//      ack=0 -> stall_out=1, wait_cnt++.
//      wait_cnt==MAX_WAIT with no ack -> mem_err<=1, stall_out=0, load data = 0, next IDLE.
//  - mem_ack is ignored in IDLE (covers a late ack after timeout or reset).
//  - Min load/store latency: req in cycle N, ack at N+1 earliest -> one stall cycle; non-memop: none.
//  - mem_wr = dm_write; mem_addr = result.
//  - mem_wdata = fwd ? wb_data : rf_data_out2,
//      fwd = rf_write_wb & (rf_write_reg_wb == rf_read_reg2) & (rf_read_reg2 != 0).
//  - MEM/WB wen = ~stall_out. Held during a stall; the WB rewrite of the same value is harmless and
//    keeps memex_data valid for the frozen EX instruction.
//  - wb_data <= memtoreg ? (ack ? mem_rdata : 0 on timeout) : result.
//  - rf_write_wb <= rf_write; a store writes rf_write_wb = 0 regardless of rf_write.
//  - Reset mid-access: mem_req drops the next cycle; the access is not retried.
//  - mem_err clears only on rst.
// STRUCTURE
//  - pipeline_pkg: mem_state_t {IDLE, BUSY}, branch code constants, REG_ZERO = 4'd0.
//  - Sub-module memwb_register (clk, rst, wen, d/q per field); FSM, counter and forward mux stay in mem_stage.
// TESTING
//  1. ALU op (rf_write=1, result=16'h1234, reg 5), no memop -> no req, no stall; next cycle wb_data=1234, rf_write_reg_wb=5.
//  2. Load addr 16'h0040, ack 1 cycle after req with rdata=16'hBEEF -> stall_out exactly 1 cycle; then wb_data=BEEF.
//  3. Store with ack after 4 cycles -> mem_req, mem_addr, mem_wdata stable for all 5 cycles; stall 4 cycles; rf_write_wb=0.
//  4. Load r3 = 16'h00AA, then store reading r3 with stale rf_data_out2=0 -> mem_wdata=16'h00AA (MEM->MEM forward).
//  5. Load with no ack -> after MAX_WAIT cycles: mem_err=1, stall drops, wb_data=0; late ack in IDLE has no effect.
//  6. rst asserted in BUSY -> next cycle mem_req=0, stall_out=0, MEM/WB outputs 0, mem_err=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 16-bit 5-stage pipeline.
// Memory-stage FSM states, branch codes carried down the pipe, and the hardwired zero register.
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_JMP  = 3'd3;

    localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/memwb_register.sv
// MEM/WB pipeline register: one d/q pair per field, loaded when wen is high.
// Latency: 1 cycle. Backpressure: wen low holds all fields.
// Reset: synchronous, clears every field.
module memwb_register #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              rf_write_d,
    input  logic [3:0]        rf_write_reg_d,
    input  logic [DATA_W-1:0] wb_data_d,
    input  logic [2:0]        branch_d,
    output logic              rf_write_q,
    output logic [3:0]        rf_write_reg_q,
    output logic [DATA_W-1:0] wb_data_q,
    output logic [2:0]        branch_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_q     <= 1'b0;
            rf_write_reg_q <= '0;
            wb_data_q      <= '0;
            branch_q       <= '0;
        end else if (wen) begin
            rf_write_q     <= rf_write_d;
            rf_write_reg_q <= rf_write_reg_d;
            wb_data_q      <= wb_data_d;
            branch_q       <= branch_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: runs the data-memory req/ack access and owns the MEM/WB register.
// Latency: non-memop 1 cycle; memop 1 + ack delay, abandoned after MAX_WAIT unacked BUSY cycles.
// Backpressure: stall_out freezes upstream stages while an access is pending.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_write,
    input  logic              dm_write,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] rf_data_out2,
    input  logic [DATA_W-1:0] result,
    input  logic [3:0]        rf_read_reg2,
    input  logic [3:0]        rf_write_reg,
    input  logic [2:0]        branch,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              mem_err,
    output logic              rf_write_wb,
    output logic [3:0]        rf_write_reg_wb,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        branch_wb
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             memop;
    logic             timeout;
    logic             fwd;
    logic [DATA_W-1:0] wb_data_d;

    assign memop   = memtoreg | dm_write;
    assign timeout = (state == BUSY) && !mem_ack && (wait_cnt == CNT_W'(MAX_WAIT));

    // EX/MEM is frozen during the access, so addr/wr/wdata stay stable without extra latching.
    assign mem_req   = (state == IDLE) ? memop : 1'b1;
    assign stall_out = (state == IDLE) ? memop : (!mem_ack && !timeout);
    assign mem_wr    = dm_write;
    assign mem_addr  = result[ADDR_W-1:0];

    // MEM->MEM forward covers load-then-store on the same register.
    assign fwd       = rf_write_wb && (rf_write_reg_wb == rf_read_reg2) && (rf_read_reg2 != REG_ZERO);
    assign mem_wdata = fwd ? wb_data : rf_data_out2;

    assign wb_data_d = memtoreg ? (mem_ack ? mem_rdata : '0) : result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        state    <= BUSY;
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state   <= IDLE;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    memwb_register #(
        .DATA_W(DATA_W)
    ) u_memwb (
        .clk            (clk),
        .rst            (rst),
        .wen            (!stall_out),
        .rf_write_d     (rf_write & ~dm_write),
        .rf_write_reg_d (rf_write_reg),
        .wb_data_d      (wb_data_d),
        .branch_d       (branch),
        .rf_write_q     (rf_write_wb),
        .rf_write_reg_q (rf_write_reg_wb),
        .wb_data_q      (wb_data),
        .branch_q       (branch_wb)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level reference model, per-cycle compare, directed and random traffic.
module tb_mem_stage;
    import pipeline_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int TO_CYC   = MAX_WAIT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_write, dm_write, memtoreg;
    logic [15:0] rf_data_out2, result, mem_rdata;
    logic [3:0]  rf_read_reg2, rf_write_reg;
    logic [2:0]  branch;
    logic        mem_ack;
    logic        mem_req, mem_wr, stall_out, mem_err, rf_write_wb;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  rf_write_reg_wb;
    logic [2:0]  branch_wb;

    mem_stage #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .rf_write(rf_write), .dm_write(dm_write), .memtoreg(memtoreg),
        .rf_data_out2(rf_data_out2), .result(result),
        .rf_read_reg2(rf_read_reg2), .rf_write_reg(rf_write_reg), .branch(branch),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_out(stall_out), .mem_err(mem_err),
        .rf_write_wb(rf_write_wb), .rf_write_reg_wb(rf_write_reg_wb),
        .wb_data(wb_data), .branch_wb(branch_wb)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Architectural model of the MEM/WB register and error flag.
    logic        m_rfw = 1'b0;
    logic [3:0]  m_reg = '0;
    logic [15:0] m_data = '0;
    logic [2:0]  m_br = '0;
    logic        m_err = 1'b0;

    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_wr;
    logic [15:0] exp_addr, exp_wdata;
    logic        force_ack = 1'b0;

    int          last_stalls, last_reqs;
    logic [15:0] first_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, exp_req);
            chk("stall_out", stall_out, exp_stall);
            if (exp_req) begin
                chk("mem_wr", mem_wr, exp_wr);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            chk("rf_write_wb", rf_write_wb, m_rfw);
            chk("rf_write_reg_wb", rf_write_reg_wb, m_reg);
            chk("wb_data", wb_data, m_data);
            chk("branch_wb", branch_wb, m_br);
            chk("mem_err", mem_err, m_err);
        end
    end

    // d = cycles from request to ack (1..TO_CYC); d = 0 means memory never answers.
    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic issue(input logic rfw, input logic dmw, input logic m2r,
                         input logic [15:0] rd2, input logic [15:0] res,
                         input logic [3:0] rr2, input logic [3:0] wr, input logic [2:0] br,
                         input int d, input logic [15:0] rdata);
        logic        memop;
        int          ncyc;
        logic [15:0] wd;
        memop = dmw | m2r;
        ncyc  = !memop ? 0 : (d == 0 ? TO_CYC : d);
        wd    = (m_rfw && m_reg == rr2 && rr2 != 4'd0) ? m_data : rd2;
        last_stalls = 0;
        last_reqs   = 0;
        for (int c = 0; c <= ncyc; c++) begin
            rf_write = rfw; dm_write = dmw; memtoreg = m2r;
            rf_data_out2 = rd2; result = res;
            rf_read_reg2 = rr2; rf_write_reg = wr; branch = br;
            if (memop && c == ncyc && d != 0) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end else begin
                // Stray acks are legal only while the FSM is idle.
                mem_ack = (!memop || c == 0) ? (force_ack | 1'($urandom_range(0, 1))) : 1'b0;
                mem_rdata = 16'($urandom);
            end
            exp_req = memop; exp_wr = dmw; exp_addr = res; exp_wdata = wd;
            exp_stall = memop && (c < ncyc);
            #2;
            if (stall_out) last_stalls++;
            if (mem_req) last_reqs++;
            if (c == 0) first_wdata = mem_wdata;
            @(posedge clk); #1;
        end
        m_rfw  = rfw & ~dmw;
        m_reg  = wr;
        m_br   = br;
        m_data = m2r ? (d == 0 ? 16'h0 : rdata) : res;
        if (memop && d == 0) m_err = 1'b1;
    endtask

    task automatic drive_bubble();
        rf_write = 0; dm_write = 0; memtoreg = 0; rf_data_out2 = 0; result = 0;
        rf_read_reg2 = 0; rf_write_reg = 0; branch = BR_NONE; mem_ack = 0; mem_rdata = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, d;
        rst = 1'b1;
        drive_bubble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_rf_write_wb", rf_write_wb, 0);
        chk("rst_reg_wb", rf_write_reg_wb, 0);
        chk("rst_branch_wb", branch_wb, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // ALU op, no memory access
        issue(1, 0, 0, 16'h0, 16'h1234, 4'd0, 4'd5, BR_BEQ, 1, 16'h0);
        chk("t1_stalls", last_stalls, 0);
        chk("t1_reqs", last_reqs, 0);
        chk("t1_wb_data", wb_data, 16'h1234);
        chk("t1_reg_wb", rf_write_reg_wb, 5);
        chk("t1_branch_wb", branch_wb, BR_BEQ);

        // Load, ack one cycle after request
        issue(1, 0, 1, 16'h0, 16'h0040, 4'd0, 4'd7, BR_NONE, 1, 16'hBEEF);
        chk("t2_stalls", last_stalls, 1);
        chk("t2_wb_data", wb_data, 16'hBEEF);
        chk("t2_rf_write_wb", rf_write_wb, 1);

        // Store, ack four cycles after request
        issue(1, 1, 0, 16'h5A5A, 16'h0100, 4'd9, 4'd2, BR_NONE, 4, 16'h0);
        chk("t3_stalls", last_stalls, 4);
        chk("t3_reqs", last_reqs, 5);
        chk("t3_rf_write_wb", rf_write_wb, 0);

        // Load r3 then store from r3 with stale register-file data
        issue(1, 0, 1, 16'h0, 16'h0060, 4'd0, 4'd3, BR_NONE, 2, 16'h00AA);
        issue(0, 1, 0, 16'h0000, 16'h0080, 4'd3, 4'd0, BR_NONE, 1, 16'h0);
        chk("t4_fwd_wdata", first_wdata, 16'h00AA);

        // Load with no ack: timeout
        issue(1, 0, 1, 16'h0, 16'h0200, 4'd0, 4'd4, BR_NONE, 0, 16'h0);
        chk("t5_stalls", last_stalls, TO_CYC);
        chk("t5_err", mem_err, 1);
        chk("t5_wb_data", wb_data, 0);
        force_ack = 1'b1;
        issue(0, 0, 0, 16'h0, 16'h0, 4'd0, 4'd0, BR_NONE, 1, 16'h0);
        issue(0, 0, 0, 16'h0, 16'h0, 4'd0, 4'd0, BR_NONE, 1, 16'h0);
        force_ack = 1'b0;
        chk("t5_late_ack_reqs", last_reqs, 0);
        issue(1, 0, 1, 16'h0, 16'h0300, 4'd0, 4'd6, BR_NONE, 2, 16'h1357);
        chk("t5_next_stalls", last_stalls, 2);
        chk("t5_next_data", wb_data, 16'h1357);
        chk("t5_err_sticky", mem_err, 1);

        // Reset in the middle of an access
        chk_en = 1'b0;
        drive_bubble();
        memtoreg = 1; rf_write = 1; result = 16'h0055; rf_write_reg = 4'd8;
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_busy_req", mem_req, 1);
        rst = 1'b1;
        drive_bubble();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_mem_req", mem_req, 0);
        chk("t6_stall", stall_out, 0);
        chk("t6_wb_data", wb_data, 0);
        chk("t6_rf_write_wb", rf_write_wb, 0);
        chk("t6_err", mem_err, 0);
        m_rfw = 0; m_reg = 0; m_data = 0; m_br = 0; m_err = 0;
        chk_en = 1'b1;

        // Random traffic; small register range to exercise forwarding
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) d = 0;
            else if ($urandom_range(0, 3) == 0) d = $urandom_range(1, TO_CYC);
            else d = $urandom_range(1, 3);
            case (kind)
                0: issue(1'($urandom_range(0, 1)), 0, 0, 16'($urandom), 16'($urandom),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom), d, 16'($urandom));
                1: issue(1, 0, 1, 16'($urandom), 16'($urandom),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom), d, 16'($urandom));
                2: issue(1'($urandom_range(0, 1)), 1, 0, 16'($urandom), 16'($urandom),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom), d, 16'($urandom));
                default: issue(0, 0, 0, 16'($urandom), 16'($urandom),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), BR_NONE, d, 16'($urandom));
            endcase
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
